channel_readout_sequencer: RTL and testbench

Sequences the readout of NCH digitizer channels that share one downstream output path. After a start pulse, it grants each enabled channel's read request in turn, waits for that channel's readout enable, and forwards the ring-buffer words with channel tag and last-word marking. It handles timeouts and early termination, and sits between the per-channel capture blocks and the event packer/SPI readout path.

---
 rtl/channel_readout_sequencer.sv | 159 +++++++++++++++
 tb/tb_channel_readout_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/channel_readout_sequencer.sv
// rtl/channel_readout_sequencer.sv - round-robin readout of digitizer channels onto one shared output path
module channel_readout_sequencer #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 12,
  parameter int SIZE    = 12,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NCH-1:0]     enable_mask,
  input  logic [SIZE-1:0]    how_many,
  input  logic [NCH-1:0]     ch_ro_enable,
  input  logic [NCH-1:0]     ch_rodone_n,
  input  logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]     read_request,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         out_channel,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [NCH-1:0]     err_timeout
);

  localparam int CW = $clog2(NCH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, REQ, STREAM, GAP, FINISH} state_t;

  state_t          state, next;
  logic [CW-1:0]   ch_idx;
  logic [SIZE-1:0] wcnt;
  logic [TW-1:0]   tcnt;
  logic [NCH-1:0]  mask_q;
  logic [SIZE-1:0] hm_q;

  logic             cur_en, cur_done_n, cur_mask, last_word, capture, at_end, tmo_hit;
  logic [WIDTH-1:0] cur_data;
  logic [NCH-1:0]   onehot;

  always_comb begin
    cur_en     = 1'b0;
    cur_done_n = 1'b1;
    cur_mask   = 1'b0;
    cur_data   = '0;
    onehot     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx == CW'(i)) begin
        cur_en     = ch_ro_enable[i];
        cur_done_n = ch_rodone_n[i];
        cur_mask   = mask_q[i];
        cur_data   = ch_data[i*WIDTH +: WIDTH];
        onehot[i]  = 1'b1;
      end
    end
  end

  // A word captured in REQ is also checked for last, so how_many==1 never enters STREAM
  always_comb begin
    next         = state;
    capture      = 1'b0;
    at_end       = (ch_idx == CW'(NCH));
    tmo_hit      = (tcnt == TW'(TIMEOUT - 1));
    last_word    = (wcnt == hm_q - SIZE'(1)) || !cur_done_n;
    read_request = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:   if (start) next = SELECT;
      SELECT: begin
        busy = 1'b1;
        if (at_end) next = FINISH;
        else if (cur_mask && hm_q != '0) next = REQ;
      end
      REQ: begin
        busy         = 1'b1;
        read_request = onehot;
        if (cur_en) begin
          capture = 1'b1;
          next    = last_word ? GAP : STREAM;
        end else if (tmo_hit) begin
          next = GAP;
        end
      end
      STREAM: begin
        busy         = 1'b1;
        read_request = onehot;
        if (cur_en) begin
          capture = 1'b1;
          if (last_word) next = GAP;
        end else begin
          next = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (!cur_en) next = SELECT;
      end
      FINISH: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ch_idx      <= '0;
      wcnt        <= '0;
      tcnt        <= '0;
      mask_q      <= '0;
      hm_q        <= '0;
      err_timeout <= '0;
      out_data    <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      state     <= next;
      out_valid <= capture;
      out_last  <= capture && last_word;
      if (capture) begin
        out_data    <= cur_data;
        out_channel <= 4'(ch_idx);
      end
      case (state)
        IDLE: if (start) begin
          mask_q      <= enable_mask;
          hm_q        <= how_many;
          err_timeout <= '0;
          ch_idx      <= '0;
        end
        SELECT: if (!at_end) begin
          if (!cur_mask || hm_q == '0) begin
            ch_idx <= ch_idx + CW'(1);
          end else begin
            wcnt <= '0;
            tcnt <= '0;
          end
        end
        REQ: begin
          if (cur_en) begin
            wcnt <= wcnt + SIZE'(1);
          end else begin
            tcnt <= tcnt + TW'(1);
            if (tmo_hit) err_timeout <= err_timeout | onehot;
          end
        end
        STREAM: if (cur_en) wcnt <= wcnt + SIZE'(1);
        GAP:    if (!cur_en) ch_idx <= ch_idx + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// tb/tb_channel_readout_sequencer.sv - table-driven bench for channel_readout_sequencer
module tb_channel_readout_sequencer;
  localparam int NCH = 4, WIDTH = 12, SIZE = 12, TIMEOUT = 255;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [NCH-1:0] enable_mask = '0, ch_ro_enable = '0;
  logic [SIZE-1:0] how_many = '0;
  wire  [NCH-1:0] ch_rodone_n;
  wire  [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0] read_request, err_timeout;
  logic [WIDTH-1:0] out_data;
  logic [3:0] out_channel;
  logic out_valid, out_last, busy, done;

  channel_readout_sequencer #(.NCH(NCH), .WIDTH(WIDTH), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .enable_mask(enable_mask), .how_many(how_many),
    .ch_ro_enable(ch_ro_enable), .ch_rodone_n(ch_rodone_n), .ch_data(ch_data),
    .read_request(read_request), .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  // Channel model: enable follows request after lat cycles (8'hFF = never); data = {ch, word index}
  int reqcnt[NCH], wc[NCH];
  bit [7:0] lat[NCH], rdat[NCH];
  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    assign ch_data[g*WIDTH +: WIDTH] = {4'(g), wc[g][7:0]};
    assign ch_rodone_n[g] = !(rdat[g] != 0 && wc[g] == int'(rdat[g]) - 1);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_ro_enable[i]) wc[i]++;
      if (read_request[i]) reqcnt[i]++; else reqcnt[i] = 0;
      ch_ro_enable[i] = read_request[i] && lat[i] != 8'hFF && reqcnt[i] > int'(lat[i]);
    end
  end

  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int reqcyc[NCH];
  logic [NCH-1:0] req_seen;
  logic [16:0] got[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) got.push_back({out_channel, out_data, out_last});
    if (done) begin done_cnt++; done_cyc = cyc; end
    req_seen = req_seen | read_request;
    for (int i = 0; i < NCH; i++) reqcyc[i] += int'(read_request[i]);
  end

  int passed = 0, total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [3:0]  mask;
    logic [11:0] hm;
    logic [31:0] lat;   // 4 x 8-bit per-channel enable latency
    logic [31:0] rdat;  // 4 x 8-bit word number at which rodone_n goes low (0 = never)
    int          exp_words;
    logic [3:0]  exp_err;
    logic [3:0]  exp_req;
  } vec_t;
  vec_t vecs[7];

  task automatic setup_model(input logic [31:0] l, input logic [31:0] r);
    for (int i = 0; i < NCH; i++) begin
      lat[i] = l[i*8 +: 8]; rdat[i] = r[i*8 +: 8]; wc[i] = 0; reqcyc[i] = 0;
    end
    got.delete(); done_cnt = 0; req_seen = '0;
  endtask

  task automatic run_pass(input vec_t v);
    int n, mism, nw;
    logic [16:0] e;
    setup_model(v.lat, v.rdat);
    @(negedge clk); enable_mask = v.mask; how_many = v.hm; start = 1'b1; start_cyc = cyc;
    @(negedge clk); start = 1'b0; enable_mask = ~v.mask; how_many = 12'd7;
    chk("busy_cycle1", busy, 1);
    @(negedge clk);
    chk("req0_cycle2", read_request[0], v.mask[0] && v.hm != 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", done_cnt != 0, 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("err_timeout", err_timeout, v.exp_err);
    chk("req_seen", req_seen, v.exp_req);
    chk("word_count", got.size(), v.exp_words);
    mism = 0; nw = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (v.mask[ch] && v.hm != 0 && v.lat[ch*8 +: 8] != 8'hFF) begin
        n = int'(v.hm);
        if (v.rdat[ch*8 +: 8] != 0 && int'(v.rdat[ch*8 +: 8]) < n) n = int'(v.rdat[ch*8 +: 8]);
        for (int j = 0; j < n; j++) begin
          e = {4'(ch), 4'(ch), 8'(j), j == n - 1};
          if (nw >= got.size() || got[nw] !== e) mism++;
          nw++;
        end
      end
      if (v.mask[ch] && v.hm != 0 && v.lat[ch*8 +: 8] == 8'hFF)
        chk("timeout_req_cycles", reqcyc[ch], TIMEOUT);
    end
    chk("stream_mismatches", mism, 0);
    if (v.exp_words == 0) chk("empty_done_latency", (done_cyc - start_cyc) <= NCH + 3, 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{4'hF, 12'd3, 32'h02020202, 32'h0, 12, 4'h0, 4'hF};
    vecs[1] = '{4'h5, 12'd2, 32'h02020202, 32'h0, 4,  4'h0, 4'h5};
    vecs[2] = '{4'hF, 12'd3, 32'h0202FF02, 32'h0, 9,  4'h2, 4'hF};
    vecs[3] = '{4'h1, 12'd8, 32'h00000001, 32'h5, 5,  4'h0, 4'h1};
    vecs[4] = '{4'h0, 12'd3, 32'h02020202, 32'h0, 0,  4'h0, 4'h0};
    vecs[5] = '{4'hF, 12'd0, 32'h02020202, 32'h0, 0,  4'h0, 4'h0};
    vecs[6] = '{4'h8, 12'd1, 32'h00000000, 32'h0, 1,  4'h0, 4'h8};
    setup_model(32'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {read_request, out_valid, out_last, busy, done, err_timeout, out_data, out_channel}, '0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) run_pass(vecs[k]);

    // Reset while channel 2 is streaming, then a clean pass must follow
    setup_model(32'h0, 32'h0);
    @(negedge clk); enable_mask = 4'hF; how_many = 12'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(read_request[2] && out_valid && out_channel == 4'd2) && n < 500) begin @(negedge clk); n++; end
    chk("reached_ch2_stream", n < 500, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {read_request, out_valid, busy, done, out_last}, '0);
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", done_cnt, 0);
    reset = 1'b0;
    run_pass(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
